ssd_display_driver: RTL and testbench

//  Downstream consumer of the CPU's 13-bit ssd output. Converts the unsigned value (0..8191)
//  to 4 BCD digits with a sequential double-dabble engine, then time-multiplexes them onto the

---
 rtl/ssd_pkg.sv | 18 +
 rtl/bcd_seg_decoder.sv | 10 +
 rtl/ssd_display_driver.sv | 91 +++++++++
 tb/tb_ssd_display_driver.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared FSM encoding, segment table and double-dabble helper for the display driver
package ssd_pkg;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int SHIFT_COUNT = 13;
  // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element
  localparam logic [9:0][6:0] SEG_LUT = {7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
                                         7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
  function automatic logic [15:0] dabble_adjust(input logic [15:0] b);
    logic [15:0] r;
    for (int j = 0; j < 4; j++)
      r[4*j +: 4] = (b[4*j +: 4] >= 4'd5) ? b[4*j +: 4] + 4'd3 : b[4*j +: 4];
    return r;
  endfunction
endpackage

// File: rtl/bcd_seg_decoder.sv
// bcd_seg_decoder: BCD nibble to active-low seven-segment pattern with blanking
module bcd_seg_decoder
  import ssd_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);
  assign seg_o = (blank_i || nibble_i > 4'd9) ? SEG_BLANK : SEG_LUT[nibble_i];
endmodule

// File: rtl/ssd_display_driver.sv
// ssd_display_driver: binary-to-BCD conversion and multiplexed 4-digit common-anode display scan
module ssd_display_driver
  import ssd_pkg::*;
#(
  parameter int REFRESH_BITS  = 20,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] ssd_value,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        busy,
  output logic        bcd_valid
);
  logic [1:0]              state_q, state_d;
  logic [12:0]             last_q, last_d;
  logic [28:0]             shreg_q, shreg_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [15:0]             disp_q, disp_d;
  logic                    busy_q, valid_q;
  logic [REFRESH_BITS-1:0] refresh_q;
  logic [3:0]              anode_q, zero, lead;
  logic [6:0]              seg_q, seg_d;
  logic [1:0]              sel;
  logic [15:0]             adj;
  assign adj = dabble_adjust(shreg_q[28:13]);
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    case (state_q)
      IDLE: state_d = (ssd_value != last_q) ? LOAD : IDLE;
      LOAD: begin
        last_d  = ssd_value;
        shreg_d = {16'h0000, ssd_value};
        cnt_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        shreg_d = {adj[14:0], shreg_q[12:0], 1'b0};
        cnt_d   = cnt_q + 4'd1;
        state_d = (cnt_q == 4'(SHIFT_COUNT - 1)) ? DONE : SHIFT;
      end
      default: begin
        disp_d  = shreg_q[28:13];
        state_d = IDLE;
      end
    endcase
  end
  // A digit is a leading zero when it and every higher digit are zero; digit 0 always shows
  assign sel  = refresh_q[REFRESH_BITS-1 -: 2];
  assign zero = {disp_q[15:12] == 4'd0, disp_q[11:8] == 4'd0, disp_q[7:4] == 4'd0, disp_q[3:0] == 4'd0};
  assign lead = {zero[3], zero[3] & zero[2], zero[3] & zero[2] & zero[1], 1'b0};
  bcd_seg_decoder u_dec (
    .nibble_i(disp_q[{sel, 2'b00} +: 4]),
    .blank_i (BLANK_LEADING && lead[sel]),
    .seg_o   (seg_d)
  );
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_q    <= '0;
      shreg_q   <= '0;
      cnt_q     <= '0;
      disp_q    <= '0;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
      refresh_q <= '0;
      anode_q   <= 4'b1111;
      seg_q     <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      busy_q    <= state_d != IDLE;
      valid_q   <= state_q == DONE;
      refresh_q <= refresh_q + 1'b1;
      anode_q   <= ~(4'b0001 << sel);
      seg_q     <= seg_d;
    end
  end
  assign anode     = anode_q;
  assign seg       = seg_q;
  assign busy      = busy_q;
  assign bcd_valid = valid_q;
endmodule

// File: tb/tb_ssd_display_driver.sv
// tb_ssd_display_driver: scoreboard and vector-table bench for ssd_display_driver
module tb_ssd_display_driver;
  logic        clk = 1'b0, reset = 1'b0;
  logic [12:0] ssd_value = '0;
  logic [3:0]  anode, anode0;
  logic [6:0]  seg, seg0;
  logic        busy, busy0, bcd_valid, bcd_valid0;
  int          checks = 0, errors = 0, nvalid = 0;
  typedef struct {
    logic [12:0]     val;
    logic [3:0][6:0] exp_bl;
    logic [3:0][6:0] exp_nb;
  } vec_t;
  vec_t sb_q[$];
  vec_t vecs[8];
  localparam logic [6:0] LUT [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  always #100 clk = ~clk;
  ssd_display_driver #(.REFRESH_BITS(4), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .reset(reset), .ssd_value(ssd_value), .anode(anode), .seg(seg),
    .busy(busy), .bcd_valid(bcd_valid));
  ssd_display_driver #(.REFRESH_BITS(4), .BLANK_LEADING(1'b0)) dut0 (
    .clk(clk), .reset(reset), .ssd_value(ssd_value), .anode(anode0), .seg(seg0),
    .busy(busy0), .bcd_valid(bcd_valid0));
  always @(negedge clk) if (bcd_valid) nvalid++;
  function automatic logic [6:0] model(int v, bit bl, int i);
    int p = 1;
    for (int k = 0; k < i; k++) p *= 10;
    if (bl && i > 0 && v < p) return 7'h7F;
    return LUT[(v / p) % 10];
  endfunction
  function automatic logic [3:0][6:0] model4(int v, bit bl);
    logic [3:0][6:0] r;
    for (int i = 0; i < 4; i++) r[i] = model(v, bl, i);
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic cmp_disp(input string name, input logic [3:0][6:0] eb, input logic [3:0][6:0] en);
    logic [3:0][6:0] s, s0;
    int bad = 0;
    s  = {4{7'h55}};
    s0 = {4{7'h55}};
    for (int t = 0; t < 16; t++) begin
      @(posedge clk); #1;
      case (anode)
        4'b1110: s[0] = seg;
        4'b1101: s[1] = seg;
        4'b1011: s[2] = seg;
        4'b0111: s[3] = seg;
        default: bad++;
      endcase
      case (anode0)
        4'b1110: s0[0] = seg0;
        4'b1101: s0[1] = seg0;
        4'b1011: s0[2] = seg0;
        4'b0111: s0[3] = seg0;
        default: bad++;
      endcase
    end
    chk($sformatf("%s onehot", name), bad, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s blank d%0d", name, i), s[i], eb[i]);
      chk($sformatf("%s full d%0d", name, i), s0[i], en[i]);
    end
  endtask
  task automatic drive(input vec_t v);
    @(negedge clk);
    ssd_value = v.val;
    sb_q.push_back(v);
  endtask
  task automatic do_check(input string name);
    vec_t e;
    int n = 0;
    while (!bcd_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("%s valid", name), bcd_valid, 1);
    chk($sformatf("%s sb nonempty", name), sb_q.size() > 0, 1);
    if (sb_q.size() > 0) e = sb_q.pop_front();
    else e = '{13'h0, {4{7'h55}}, {4{7'h55}}};
    cmp_disp($sformatf("%s v%0d", name, e.val), e.exp_bl, e.exp_nb);
  endtask
  initial begin
    int n, nv0, t0, idx0, ei;
    logic [3:0] a [40];
    logic [3:0] ea;
    #(200 * 20000);
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end
  initial begin
    int n, nv0, t0, idx0, ei;
    logic [3:0] a [40];
    logic [3:0] ea;
    vecs[0] = '{13'd8191, {7'h00, 7'h79, 7'h10, 7'h79}, {7'h00, 7'h79, 7'h10, 7'h79}};
    vecs[1] = '{13'd7, model4(7, 1), {7'h40, 7'h40, 7'h40, 7'h78}};
    vecs[2] = '{13'd10, model4(10, 1), model4(10, 0)};
    vecs[3] = '{13'd100, model4(100, 1), model4(100, 0)};
    vecs[4] = '{13'd5000, model4(5000, 1), model4(5000, 0)};
    vecs[5] = '{13'd9, model4(9, 1), model4(9, 0)};
    vecs[6] = '{13'd1000, model4(1000, 1), model4(1000, 0)};
    vecs[7] = '{13'd0, {7'h7F, 7'h7F, 7'h7F, 7'h40}, model4(0, 0)};
    // reset state and idle display
    repeat (3) @(posedge clk);
    #1;
    chk("rst anode", anode, 4'b1111);
    chk("rst seg", seg, 7'h7F);
    chk("rst busy", busy, 0);
    chk("rst valid", bcd_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk($sformatf("idle busy %0d", i), busy, 0);
    end
    cmp_disp("idle", {7'h7F, 7'h7F, 7'h7F, 7'h40}, {7'h40, 7'h40, 7'h40, 7'h40});
    // latency of a single conversion
    @(negedge clk);
    ssd_value = 13'd1234;
    sb_q.push_back('{13'd1234, {7'h79, 7'h24, 7'h30, 7'h19}, model4(1234, 0)});
    nv0 = nvalid;
    @(posedge clk); #1;
    chk("t2 busy at detect", busy, 1);
    n = 0;
    while (!bcd_valid && n < 30) begin
      @(posedge clk); #1;
      n++;
      if (n == 14) chk("t2 busy k+14", busy, 1);
    end
    chk("t2 valid latency", n, 15);
    do_check("t2");
    chk("t2 one pulse", nvalid - nv0, 1);
    chk("t2 busy idle", busy, 0);
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i]);
      do_check($sformatf("vec%0d", i));
    end
    // value change during a conversion
    nv0 = nvalid;
    drive('{13'd1234, model4(1234, 1), model4(1234, 0)});
    repeat (4) @(negedge clk);
    drive('{13'd42, {7'h7F, 7'h7F, 7'h19, 7'h24}, model4(42, 0)});
    do_check("t4a");
    do_check("t4b");
    repeat (5) @(posedge clk);
    #1;
    chk("t4 pulse count", nvalid - nv0, 2);
    chk("t4 busy end", busy, 0);
    // async reset in the middle of a conversion
    @(negedge clk);
    ssd_value = 13'd999;
    @(posedge clk);
    repeat (6) @(posedge clk);
    #50;
    reset = 1'b0;
    #1;
    chk("t5 anode", anode, 4'b1111);
    chk("t5 seg", seg, 7'h7F);
    chk("t5 busy", busy, 0);
    chk("t5 valid", bcd_valid, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sb_q.push_back('{13'd999, {7'h7F, 7'h10, 7'h10, 7'h10}, model4(999, 0)});
    do_check("t5");
    // scan order and dwell
    for (int t = 0; t < 40; t++) begin
      @(posedge clk); #1;
      a[t] = anode;
    end
    t0 = 0;
    for (int t = 39; t > 0; t--) if (a[t] != a[t-1]) t0 = t;
    chk("t6 transition found", t0 > 0 && t0 <= 4, 1);
    idx0 = 0;
    for (int b = 0; b < 4; b++) if (a[t0][b] == 1'b0) idx0 = b;
    for (int t = t0; t < 40; t++) begin
      ei = (idx0 + (t - t0) / 4) % 4;
      ea = ~(4'b0001 << ei);
      chk($sformatf("t6 anode %0d", t), a[t], ea);
    end
    chk("sb empty", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
